// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared sequencer state enum and default frame geometry
package fft_pkg;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_FFT_POINTS = 64;
  localparam int DEF_ADDR_WIDTH = 6;
  localparam int DEF_TIMEOUT    = 4096;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_START  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_UNLOAD = 3'd4
  } fft_state_e;

endpackage

// File: rtl/fft_out_skid.sv
// rtl/fft_out_skid.sv - two-entry output buffer; entry 0 is always the head
module fft_out_skid #(
  parameter int DATA_WIDTH = fft_pkg::DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_tvalid_i,
  input  logic [2*DATA_WIDTH-1:0] in_tdata_i,
  input  logic                    in_tlast_i,
  output logic                    out_tvalid_o,
  input  logic                    out_tready_i,
  output logic [2*DATA_WIDTH-1:0] out_tdata_o,
  output logic                    out_tlast_o,
  output logic [1:0]              count_o
);

  localparam int ENT_W = 2 * DATA_WIDTH + 1;

  logic [ENT_W-1:0] ent0_q, ent0_d;
  logic [ENT_W-1:0] ent1_q, ent1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [ENT_W-1:0] push_word;
  logic             pop;

  assign out_tvalid_o = (cnt_q != 2'd0);
  assign pop          = out_tvalid_o & out_tready_i;
  assign push_word    = {in_tlast_i, in_tdata_i};

  // The writer only pushes when an entry will be free, so a push into a full buffer never happens.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({in_tvalid_i, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_word;
        else               ent1_d = push_word;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_word;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_word;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign out_tdata_o = ent0_q[2*DATA_WIDTH-1:0];
  assign out_tlast_o = ent0_q[2*DATA_WIDTH] & out_tvalid_o;
  assign count_o     = cnt_q;

endmodule

// File: rtl/fft_stream_sequencer.sv
// rtl/fft_stream_sequencer.sv - streams a frame into an FFT core, waits for done, streams bins out
module fft_stream_sequencer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FFT_POINTS = DEF_FFT_POINTS,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_real,
  input  logic [DATA_WIDTH-1:0] s_imag,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_real,
  output logic [DATA_WIDTH-1:0] m_imag,
  output logic                  m_last,
  output logic                  core_start,
  output logic                  core_data_valid,
  output logic [DATA_WIDTH-1:0] core_data_real,
  output logic [DATA_WIDTH-1:0] core_data_imag,
  output logic [ADDR_WIDTH-1:0] core_addr_in,
  output logic                  core_rd_en,
  output logic [ADDR_WIDTH-1:0] core_addr_out,
  input  logic                  core_busy,
  input  logic                  core_done,
  input  logic [DATA_WIDTH-1:0] core_data_out_real,
  input  logic [DATA_WIDTH-1:0] core_data_out_imag,
  output logic                  seq_busy,
  output logic                  err_timeout,
  output logic [15:0]           frame_count
);

  localparam int TIMER_W = $clog2(TIMEOUT + 1);
  localparam int RD_W    = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(FFT_POINTS - 1);
  localparam logic [RD_W-1:0]       RD_END     = RD_W'(FFT_POINTS);
  localparam logic [TIMER_W-1:0]    TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  fft_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  load_cnt_q, load_cnt_d;
  logic [RD_W-1:0]        rd_cnt_q, rd_cnt_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   err_q, err_d;
  logic [15:0]            frame_cnt_q, frame_cnt_d;
  logic                   rd_pend_q;
  logic                   rd_pend_last_q;

  logic                    buf_valid;
  logic                    buf_last;
  logic [1:0]              buf_count;
  logic [2*DATA_WIDTH-1:0] buf_data;
  logic                    pop;
  logic [2:0]              occ_next;
  logic                    buf_room;

  logic unused_core_busy;
  assign unused_core_busy = core_busy;

  assign pop = buf_valid & m_ready;

  // Occupancy the buffer will have once this cycle's pop and the in-flight read land;
  // a new read is only issued if its data will still find a free entry.
  assign occ_next = {1'b0, buf_count} + {2'b00, rd_pend_q} - {2'b00, pop};
  assign buf_room = (occ_next < 3'd2);

  always_comb begin
    state_d         = state_q;
    load_cnt_d      = load_cnt_q;
    rd_cnt_d        = rd_cnt_q;
    timer_d         = timer_q;
    err_d           = err_q;
    frame_cnt_d     = frame_cnt_q;
    s_ready         = 1'b0;
    core_start      = 1'b0;
    core_data_valid = 1'b0;
    core_rd_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_valid) state_d = ST_LOAD;
      end

      ST_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          core_data_valid = 1'b1;
          load_cnt_d      = load_cnt_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (load_cnt_q == LAST_ADDR) state_d = ST_START;
        end
      end

      ST_START: begin
        core_start = 1'b1;
        timer_d    = '0;
        state_d    = ST_WAIT;
      end

      ST_WAIT: begin
        if (core_done) begin
          rd_cnt_d = '0;
          timer_d  = '0;
          state_d  = ST_UNLOAD;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          timer_d = '0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q + {{(TIMER_W-1){1'b0}}, 1'b1};
        end
      end

      ST_UNLOAD: begin
        if ((rd_cnt_q < RD_END) && buf_room) begin
          core_rd_en = 1'b1;
          rd_cnt_d   = rd_cnt_q + {{(RD_W-1){1'b0}}, 1'b1};
        end
        if (pop && buf_last) begin
          rd_cnt_d    = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      load_cnt_q     <= '0;
      rd_cnt_q       <= '0;
      timer_q        <= '0;
      err_q          <= 1'b0;
      frame_cnt_q    <= 16'd0;
      rd_pend_q      <= 1'b0;
      rd_pend_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      load_cnt_q     <= load_cnt_d;
      rd_cnt_q       <= rd_cnt_d;
      timer_q        <= timer_d;
      err_q          <= err_d;
      frame_cnt_q    <= frame_cnt_d;
      rd_pend_q      <= core_rd_en;
      rd_pend_last_q <= core_rd_en & (core_addr_out == LAST_ADDR);
    end
  end

  assign core_addr_in   = load_cnt_q;
  assign core_addr_out  = rd_cnt_q[ADDR_WIDTH-1:0];
  assign core_data_real = (state_q == ST_LOAD) ? s_real : '0;
  assign core_data_imag = (state_q == ST_LOAD) ? s_imag : '0;

  // Core read data is valid the cycle after core_rd_en, which is exactly when rd_pend_q is set.
  fft_out_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_skid (
    .clk          (clk),
    .rst          (rst),
    .in_tvalid_i  (rd_pend_q),
    .in_tdata_i   ({core_data_out_real, core_data_out_imag}),
    .in_tlast_i   (rd_pend_last_q),
    .out_tvalid_o (buf_valid),
    .out_tready_i (m_ready),
    .out_tdata_o  (buf_data),
    .out_tlast_o  (buf_last),
    .count_o      (buf_count)
  );

  assign m_valid     = buf_valid;
  assign m_last      = buf_last;
  assign m_real      = buf_data[2*DATA_WIDTH-1:DATA_WIDTH];
  assign m_imag      = buf_data[DATA_WIDTH-1:0];
  assign seq_busy    = (state_q != ST_IDLE);
  assign err_timeout = err_q;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_fft_stream_sequencer.sv
// tb/tb_fft_stream_sequencer.sv - directed bench with a small FFT core model and expected-bin table
module tb_fft_stream_sequencer;

  localparam int DW = 16;
  localparam int NP = 64;
  localparam int AW = 6;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready;
  logic [DW-1:0] s_real, s_imag;
  logic          m_valid, m_ready, m_last;
  logic [DW-1:0] m_real, m_imag;
  logic          core_start, core_data_valid, core_rd_en, core_busy, core_done;
  logic [DW-1:0] core_data_real, core_data_imag, core_data_out_real, core_data_out_imag;
  logic [AW-1:0] core_addr_in, core_addr_out;
  logic          seq_busy, err_timeout;
  logic [15:0]   frame_count;

  always #5 clk = ~clk;

  fft_stream_sequencer #(
    .DATA_WIDTH (DW),
    .FFT_POINTS (NP),
    .ADDR_WIDTH (AW),
    .TIMEOUT    (TO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .s_real             (s_real),
    .s_imag             (s_imag),
    .m_valid            (m_valid),
    .m_ready            (m_ready),
    .m_real             (m_real),
    .m_imag             (m_imag),
    .m_last             (m_last),
    .core_start         (core_start),
    .core_data_valid    (core_data_valid),
    .core_data_real     (core_data_real),
    .core_data_imag     (core_data_imag),
    .core_addr_in       (core_addr_in),
    .core_rd_en         (core_rd_en),
    .core_addr_out      (core_addr_out),
    .core_busy          (core_busy),
    .core_done          (core_done),
    .core_data_out_real (core_data_out_real),
    .core_data_out_imag (core_data_out_imag),
    .seq_busy           (seq_busy),
    .err_timeout        (err_timeout),
    .frame_count        (frame_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [DW-1:0] mem_r [NP];
  logic [DW-1:0] mem_i [NP];
  logic [AW-1:0] rd_addr;
  bit rd_pend, src_valid, gaps, spur, spur_off, saw_mvalid;
  int cyc = 0;
  int cur_base, ready_pct, done_delay, done_cd;
  int n_in, exp_bin, lasts, last_total;
  int start_cyc, first_mv_cyc, last_pop_cyc, err_cyc;

  task automatic step();
    @(negedge clk);
    cyc++;
    if (rd_pend) begin
      core_data_out_real = mem_r[rd_addr] + 16'h0100;
      core_data_out_imag = mem_i[rd_addr] ^ 16'h5A5A;
    end else begin
      core_data_out_real = 16'hDEAD;
      core_data_out_imag = 16'hBEEF;
    end
    core_done = 1'b0;
    if (done_cd > 0) begin
      done_cd--;
      if (done_cd == 0) core_done = 1'b1;
    end
    if (spur && !spur_off) core_done = 1'b1;
    core_busy = (done_cd > 0);
    if (!src_valid && n_in < NP && (!gaps || $urandom_range(0, 1) == 1)) src_valid = 1'b1;
    s_valid = src_valid;
    s_real  = 16'(cur_base + n_in);
    s_imag  = 16'h0000;
    m_ready = ($urandom_range(0, 99) < ready_pct);
    #1;
    rd_pend = core_rd_en;
    rd_addr = core_addr_out;
    if (core_data_valid) begin
      mem_r[core_addr_in] = core_data_real;
      mem_i[core_addr_in] = core_data_imag;
    end
    if (core_start) begin
      start_cyc = cyc;
      spur_off  = 1'b1;
      if (done_delay > 0) done_cd = done_delay;
    end
    if (s_valid && s_ready) begin
      src_valid = 1'b0;
      n_in++;
    end
    if (m_valid && !saw_mvalid) begin
      saw_mvalid   = 1'b1;
      first_mv_cyc = cyc;
    end
    if (m_valid && m_ready) begin
      chk("bin_real", m_real, 16'(cur_base + exp_bin + 256));
      chk("bin_imag", m_imag, 16'h5A5A);
      chk("bin_last", m_last, (exp_bin == NP - 1));
      if (m_last) lasts++;
      last_pop_cyc = cyc;
      exp_bin++;
    end
    if (err_timeout && err_cyc < 0) err_cyc = cyc;
  endtask

  // mode 0: until m_last popped, 1: until stop_at samples loaded, 2: until stop_at bins popped, 3: until err_timeout
  task automatic run_frame(input string tag, input int b, input bit g, input int rp, input int dd,
                           input bit sp, input int mode, input int stop_at);
    bit finished;
    int limit;
    cur_base = b; gaps = g; ready_pct = rp; done_delay = dd; spur = sp; spur_off = 1'b0;
    n_in = 0; src_valid = 1'b0; exp_bin = 0; lasts = 0; saw_mvalid = 1'b0;
    start_cyc = -1; first_mv_cyc = -1; last_pop_cyc = -1; err_cyc = -1;
    finished = 1'b0;
    limit = cyc + 3000;
    while (!finished && cyc < limit) begin
      step();
      case (mode)
        0:       finished = (lasts > 0);
        1:       finished = (n_in >= stop_at);
        2:       finished = (exp_bin >= stop_at);
        default: finished = (err_cyc >= 0);
      endcase
    end
    chk({"budget_", tag}, finished, 1'b1);
    if (mode == 0 || mode == 3) step();
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; core_done = 1'b0; core_busy = 1'b0;
    src_valid = 1'b0; rd_pend = 1'b0; done_cd = 0; spur = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk({tag, "_ctrl"}, {s_ready, m_valid, m_last, core_start, core_data_valid, core_rd_en,
                         seq_busy, err_timeout}, 8'h00);
    chk({tag, "_mdata"}, {m_real, m_imag}, 32'h0);
    chk({tag, "_addr"}, {core_addr_in, core_addr_out}, 12'h0);
    chk({tag, "_fc"}, frame_count, 16'd0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_real = '0; s_imag = '0; m_ready = 1'b0;
    core_done = 1'b0; core_busy = 1'b0; core_data_out_real = '0; core_data_out_imag = '0;
    rd_pend = 1'b0; done_cd = 0; spur = 1'b0; src_valid = 1'b0;
    repeat (3) @(negedge clk);
    do_reset("rst_init");

    run_frame("A", 0, 1'b0, 100, 10, 1'b0, 0, 0);
    chk("A_bins", exp_bin, 64);
    chk("A_lasts", lasts, 1);
    chk("A_fc", frame_count, 16'd1);
    chk("A_latency", first_mv_cyc - start_cyc, 13);
    chk("A_rate", last_pop_cyc - first_mv_cyc, 63);
    chk("A_idle", seq_busy, 1'b0);

    run_frame("B", 0, 1'b1, 30, 10, 1'b0, 0, 0);
    chk("B_bins", exp_bin, 64);
    chk("B_lasts", lasts, 1);
    chk("B_fc", frame_count, 16'd2);

    run_frame("SP", 100, 1'b0, 100, 10, 1'b1, 0, 0);
    chk("SP_bins", exp_bin, 64);
    chk("SP_latency", first_mv_cyc - start_cyc, 13);
    chk("SP_fc", frame_count, 16'd3);

    last_total = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame("BB", 1000 + f * 64, 1'b0, 100, 10, 1'b0, 0, 0);
      last_total += lasts;
    end
    chk("BB_lasts", last_total, 3);
    chk("BB_fc", frame_count, 16'd6);

    run_frame("TO", 2000, 1'b0, 100, 0, 1'b0, 3, 0);
    chk("TO_err_cycle", err_cyc - start_cyc, TO + 1);
    chk("TO_no_mvalid", saw_mvalid, 1'b0);
    chk("TO_idle", seq_busy, 1'b0);
    chk("TO_fc", frame_count, 16'd6);

    run_frame("PT", 3000, 1'b1, 50, 10, 1'b0, 0, 0);
    chk("PT_bins", exp_bin, 64);
    chk("PT_fc", frame_count, 16'd7);
    chk("PT_err_sticky", err_timeout, 1'b1);

    run_frame("RL", 4000, 1'b0, 100, 10, 1'b0, 1, 20);
    do_reset("rst_load");
    run_frame("F1", 5000, 1'b0, 100, 10, 1'b0, 0, 0);
    chk("F1_bins", exp_bin, 64);
    chk("F1_fc", frame_count, 16'd1);

    run_frame("RU", 6000, 1'b0, 100, 10, 1'b0, 2, 30);
    do_reset("rst_unload");
    run_frame("F2", 7000, 1'b1, 30, 10, 1'b0, 0, 0);
    chk("F2_bins", exp_bin, 64);
    chk("F2_lasts", lasts, 1);
    chk("F2_fc", frame_count, 16'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
